// File: rtl/writeback_stage_pkg.sv
// Shared configuration for the writeback stage: datapath widths, register
// count and the FSM state encodings.
package writeback_stage_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int DMEM_ADDR_WIDTH = 16;
  localparam int REGS_COUNT      = 16;
  localparam int REG_IDX_WIDTH   = $clog2(REGS_COUNT);

  localparam logic [1:0] STATE_IDLE     = 2'd0;
  localparam logic [1:0] STATE_WAIT_MEM = 2'd1;
  localparam logic [1:0] STATE_WRITE    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE     = STATE_IDLE,
    ST_WAIT_MEM = STATE_WAIT_MEM,
    ST_WRITE    = STATE_WRITE
  } wb_state_e;

  typedef logic [DMEM_DATA_WIDTH-1:0] data_t;
  typedef logic [DMEM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [REG_IDX_WIDTH-1:0]   reg_idx_t;

  // Register 0 is hardwired, so it never takes a write or a hazard slot.
  function automatic logic is_live_reg(input reg_idx_t idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of the upstream, data-memory and register-file signals of the
// writeback stage; the stage uses the slave view.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic     in_valid;
  logic     in_ready;
  logic     in_src;
  reg_idx_t in_reg_d;
  data_t    in_value;
  addr_t    in_addr;

  logic     dmem_req;
  addr_t    dmem_addr;
  logic     dmem_ack;
  data_t    dmem_data;

  logic     reg_d_enable;
  reg_idx_t reg_d;
  data_t    reg_d_value;

  logic     pending_valid;
  reg_idx_t pending_reg;
  logic     err_timeout;

  modport slave (
    input  in_valid, in_src, in_reg_d, in_value, in_addr, dmem_ack, dmem_data,
    output in_ready, dmem_req, dmem_addr, reg_d_enable, reg_d, reg_d_value,
           pending_valid, pending_reg, err_timeout
  );

  modport master (
    output in_valid, in_src, in_reg_d, in_value, in_addr, dmem_ack, dmem_data,
    input  in_ready, dmem_req, dmem_addr, reg_d_enable, reg_d, reg_d_value,
           pending_valid, pending_reg, err_timeout
  );

endinterface

// File: rtl/writeback_stage_timeout_counter.sv
// 8-bit load-wait counter; terminal_o fires in the counting cycle that
// brings the count up to LIMIT.
module wb_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic terminal_o
);

  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU results directly and loads via the data
// memory, issuing one register-file write per completed operation.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input logic         clk,
  input logic         rst,
  writeback_stage_if.slave bus
);

  wb_state_e state_q, state_d;
  reg_idx_t  dest_q, dest_d;
  data_t     value_q, value_d;
  addr_t     addr_q, addr_d;
  logic      req_q, req_d;
  logic      wr_en_q, wr_en_d;
  logic      err_q, err_d;

  logic in_ready_w;
  logic transfer;
  logic load_start;
  logic wait_count;
  logic timeout_hit;

  assign in_ready_w = (state_q != ST_WAIT_MEM);
  assign transfer   = bus.in_valid && in_ready_w;
  assign load_start = transfer && bus.in_src;
  assign wait_count = (state_q == ST_WAIT_MEM) && !bus.dmem_ack;

  wb_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (load_start),
    .enable_i   (wait_count),
    .terminal_o (timeout_hit)
  );

  // Strobe and request are computed from the next state so both leave
  // flops, keeping the register-file write port glitch-free.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    value_d = value_q;
    addr_d  = addr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (transfer) begin
          dest_d = bus.in_reg_d;
          if (bus.in_src) begin
            addr_d  = bus.in_addr;
            state_d = ST_WAIT_MEM;
          end else begin
            value_d = bus.in_value;
            state_d = ST_WRITE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_MEM: begin
        if (bus.dmem_ack) begin
          value_d = bus.dmem_data;
          state_d = ST_WRITE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d   = (state_d == ST_WAIT_MEM);
    wr_en_d = (state_d == ST_WRITE) && is_live_reg(dest_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dest_q  <= '0;
      value_q <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      value_q <= value_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      wr_en_q <= wr_en_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready      = in_ready_w;
  assign bus.dmem_req      = req_q;
  assign bus.dmem_addr     = addr_q;
  assign bus.reg_d_enable  = wr_en_q;
  assign bus.reg_d         = dest_q;
  assign bus.reg_d_value   = value_q;
  assign bus.pending_valid = (state_q != ST_IDLE) && is_live_reg(dest_q);
  assign bus.pending_reg   = dest_q;
  assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random ALU/load traffic,
// checked against an expected register file and per-operation timing rules.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  writeback_stage_if bus();

  writeback_stage #(
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;
  int expWrites = 0;
  int seenWrites = 0;
  logic errExp = 1'b0;
  logic [31:0] expRegs [16];
  logic [31:0] seenRegs [16];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Register-file side: record every strobed write as the real file would.
  always @(negedge clk) begin
    if (!rst && bus.reg_d_enable) begin
      checkOutput("wrNonZero", 32'(bus.reg_d != 4'd0), 32'd1);
      seenRegs[bus.reg_d] = bus.reg_d_value;
      seenWrites++;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid  = 1'b0;
      bus.dmem_ack  = 1'($urandom_range(0, 1));
      bus.dmem_data = $urandom;
      @(posedge clk);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      checkOutput("idleEnable", 32'(bus.reg_d_enable), 32'd0);
      checkOutput("idleReq", 32'(bus.dmem_req), 32'd0);
      checkOutput("idlePending", 32'(bus.pending_valid), 32'd0);
      checkOutput("idleReady", 32'(bus.in_ready), 32'd1);
      checkOutput("idleErr", 32'(bus.err_timeout), 32'(errExp));
    end
  endtask

  task automatic checkWrite(input string tag, input logic [3:0] r, input logic [31:0] v);
    checkOutput({tag, "Enable"}, 32'(bus.reg_d_enable), 32'(r != 4'd0));
    checkOutput({tag, "Pending"}, 32'(bus.pending_valid), 32'(r != 4'd0));
    checkOutput({tag, "Ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, "Err"}, 32'(bus.err_timeout), 32'(errExp));
    if (r != 4'd0) begin
      checkOutput({tag, "Reg"}, 32'(bus.reg_d), 32'(r));
      checkOutput({tag, "Value"}, bus.reg_d_value, v);
      expRegs[r] = v;
      expWrites++;
    end
  endtask

  task automatic aluOp(input logic [3:0] r, input logic [31:0] v);
    checkOutput("aluReadyIn", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_src   = 1'b0;
    bus.in_reg_d = r;
    bus.in_value = v;
    bus.in_addr  = 16'($urandom);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkWrite("alu", r, v);
  endtask

  // ackAt = cycle of WAIT_MEM (1-based) carrying the ack; 0 means never.
  task automatic loadOp(input logic [3:0] r, input logic [15:0] a,
                        input int ackAt, input logic [31:0] d);
    logic acked;
    acked = 1'b0;
    checkOutput("ldReadyIn", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_src   = 1'b1;
    bus.in_reg_d = r;
    bus.in_addr  = a;
    bus.in_value = $urandom;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= TO; k++) begin
      checkOutput("ldReq", 32'(bus.dmem_req), 32'd1);
      checkOutput("ldReady", 32'(bus.in_ready), 32'd0);
      checkOutput("ldAddr", 32'(bus.dmem_addr), 32'(a));
      checkOutput("ldPendReg", 32'(bus.pending_reg), 32'(r));
      checkOutput("ldPendValid", 32'(bus.pending_valid), 32'(r != 4'd0));
      checkOutput("ldNoWrite", 32'(bus.reg_d_enable), 32'd0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_src   = 1'($urandom_range(0, 1));
      bus.in_reg_d = 4'($urandom);
      bus.in_value = $urandom;
      acked = (k == ackAt);
      bus.dmem_ack  = acked;
      bus.dmem_data = acked ? d : $urandom;
      @(posedge clk);
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      bus.in_valid = 1'b0;
      if (acked) break;
    end
    if (acked) begin
      checkOutput("ldReqDrop", 32'(bus.dmem_req), 32'd0);
      checkWrite("ld", r, d);
    end else begin
      errExp = 1'b1;
      checkOutput("toReq", 32'(bus.dmem_req), 32'd0);
      checkOutput("toErr", 32'(bus.err_timeout), 32'd1);
      checkOutput("toNoWrite", 32'(bus.reg_d_enable), 32'd0);
      checkOutput("toReady", 32'(bus.in_ready), 32'd1);
      checkOutput("toPending", 32'(bus.pending_valid), 32'd0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Enable"}, 32'(bus.reg_d_enable), 32'd0);
    checkOutput({tag, "Req"}, 32'(bus.dmem_req), 32'd0);
    checkOutput({tag, "Addr"}, 32'(bus.dmem_addr), 32'd0);
    checkOutput({tag, "Reg"}, 32'(bus.reg_d), 32'd0);
    checkOutput({tag, "Value"}, bus.reg_d_value, 32'd0);
    checkOutput({tag, "Pending"}, 32'(bus.pending_valid), 32'd0);
    checkOutput({tag, "PendReg"}, 32'(bus.pending_reg), 32'd0);
    checkOutput({tag, "Err"}, 32'(bus.err_timeout), 32'd0);
  endtask

  task automatic applyStimulus();
    logic [3:0] r;
    int op;
    int ackAt;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 2);
      r  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      if (op < 2) begin
        aluOp(r, $urandom);
      end else begin
        ackAt = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
        loadOp(r, 16'($urandom), ackAt, $urandom);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      expRegs[i]  = '0;
      seenRegs[i] = '0;
    end
    bus.in_valid  = 1'b0;
    bus.in_src    = 1'b0;
    bus.in_reg_d  = '0;
    bus.in_value  = '0;
    bus.in_addr   = '0;
    bus.dmem_ack  = 1'b0;
    bus.dmem_data = '0;

    @(negedge clk);
    @(negedge clk);
    checkResetOutputs("rstHold");
    rst = 1'b0;
    #1;
    checkOutput("rstReady", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    aluOp(4'd3, 32'h5A);
    idle(1);
    aluOp(4'd1, 32'h11);
    aluOp(4'd2, 32'h22);
    aluOp(4'd3, 32'h33);
    idle(1);
    loadOp(4'd7, 16'h0010, 4, 32'hC3);
    idle(1);
    loadOp(4'd6, 16'h0030, TO, 32'hAB);
    idle(1);
    loadOp(4'd4, 16'h0020, 0, 32'h0);
    idle(2);
    aluOp(4'd0, 32'hDEAD);
    loadOp(4'd0, 16'h0044, 3, 32'hBEEF);
    idle(1);

    // Reset in the middle of a write: the strobe must vanish at once.
    bus.in_valid = 1'b1;
    bus.in_src   = 1'b0;
    bus.in_reg_d = 4'd9;
    bus.in_value = 32'h99;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    bus.in_valid = 1'b0;
    errExp = 1'b0;
    checkResetOutputs("rstWrite");
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Reset while a load is outstanding, then a late ack must be ignored.
    loadOp(4'd4, 16'h0020, 0, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_src   = 1'b1;
    bus.in_reg_d = 4'd5;
    bus.in_addr  = 16'h0055;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("rstLoadReq", 32'(bus.dmem_req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    errExp = 1'b0;
    checkResetOutputs("rstLoad");
    checkOutput("rstLoadReady", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.dmem_ack  = 1'b1;
    bus.dmem_data = 32'h5555;
    @(posedge clk);
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    checkOutput("lateAckEnable", 32'(bus.reg_d_enable), 32'd0);
    idle(3);

    applyStimulus();
    idle(2);

    for (int i = 1; i < 16; i++) begin
      checkOutput($sformatf("regFile%0d", i), seenRegs[i], expRegs[i]);
    end
    checkOutput("writeCount", 32'(seenWrites), 32'(expWrites));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, the maximum WAIT_MEM cycles without dmem_ack before abort (range 1..255).
REQ-002 Clock is clk and reset is rst: one clock, reset asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  async active-high reset.
REQ-005 in_valid  in  1  upstream result valid.
REQ-006 in_ready  out  1  stage can accept this cycle.
REQ-007 in_src  in  1  0=ALU value, 1=memory load.
REQ-008 in_reg_d  in  4  destination register index.
REQ-009 in_value  in  DMEM_DATA_WIDTH  ALU result, used when in_src=0.
REQ-010 in_addr  in  DMEM_ADDR_WIDTH  load address, used when in_src=1.
REQ-011 dmem_req  out  1  load request, held until ack.
REQ-012 dmem_addr  out  DMEM_ADDR_WIDTH  load address.
REQ-013 dmem_ack  in  1  load data valid.
REQ-014 dmem_data  in  DMEM_DATA_WIDTH  load data.
REQ-015 reg_d_enable  out  1  register-file write strobe, one-cycle pulse.
REQ-016 reg_d  out  4  write index.
REQ-017 reg_d_value  out  DMEM_DATA_WIDTH  write data.
REQ-018 pending_valid  out  1  a write is in flight.
REQ-019 pending_reg  out  4  in-flight destination, for hazard checks.
REQ-020 err_timeout  out  1  sticky load-timeout flag.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, WAIT_MEM and WRITE.
REQ-022 in_ready SHALL be 1 in IDLE and WRITE and 0 in WAIT_MEM, and a transfer SHALL occur when in_valid and in_ready are both 1.
REQ-023 An ALU transfer SHALL latch in_reg_d and in_value and enter WRITE, so the write strobe occurs exactly 1 cycle after the transfer.
REQ-024 A load transfer SHALL latch in_reg_d and in_addr, enter WAIT_MEM, and hold dmem_req=1 with dmem_addr stable until dmem_ack.
REQ-025 On dmem_ack in WAIT_MEM, the stage SHALL capture dmem_data and enter WRITE, so the strobe occurs 1 cycle after the ack.
REQ-026 In WRITE, reg_d_enable SHALL be 1 for one cycle with reg_d and reg_d_value driven from the latched values.
REQ-027 On leaving WRITE, the next state SHALL be WAIT_MEM for a new load transfer, WRITE for a new ALU transfer (back-to-back, one write per cycle), and IDLE otherwise.
REQ-028 When the destination is 0, the stage SHALL keep reg_d_enable at 0, SHALL still perform any load, and SHALL keep the same state sequence and timing.
REQ-029 pending_valid SHALL be 1 in WAIT_MEM and WRITE and SHALL equal 0 when the destination is 0, with pending_reg equal to the latched destination.
REQ-030 A timeout counter SHALL be 8 bits, clear on entering WAIT_MEM, and increment each WAIT_MEM cycle without ack.
REQ-031 On reaching TIMEOUT_CYCLES, the stage SHALL drop dmem_req, set err_timeout, return to IDLE, and perform no write.
REQ-032 When dmem_ack arrives in the same cycle that the timeout is reached, the ack SHALL take precedence and the write SHALL proceed.
REQ-033 The stage SHALL ignore dmem_ack outside WAIT_MEM.
REQ-034 err_timeout SHALL clear only on rst.
REQ-035 reg_d_enable and dmem_req SHALL be registered outputs, glitch-free to the register-file write port.

Reset
REQ-036 rst SHALL force IDLE immediately, including mid-load or mid-write, and the aborted operation SHALL produce no write.
REQ-037 During and after rst, all outputs SHALL be 0 except in_ready, which SHALL be 1 after reset release.
REQ-038 The latched registers and the timeout counter SHALL reset to 0.

Structure
REQ-039 DMEM_DATA_WIDTH, DMEM_ADDR_WIDTH and REGS_COUNT SHALL come from the shared config include, and the state encodings SHALL be defined there as localparams.
REQ-040 The timeout counter SHALL be implemented as the single sub-module wb_timeout_counter, with clear, enable, and terminal-count output.

Verification
REQ-041 ALU transfer (reg_d=3, in_value=0x5A) -> the next cycle shows reg_d_enable=1, reg_d=3, reg_d_value=0x5A for exactly one cycle.
REQ-042 Three back-to-back ALU transfers to r1, r2, r3 -> three consecutive write pulses, with in_ready=1 throughout.
REQ-043 Load to r7 at addr 0x10 with ack after 4 cycles, data 0xC3 -> dmem_req is high for 4 cycles, in_ready=0, pending_reg=7, and the write 0xC3 lands 1 cycle after the ack.
REQ-044 Load with no ack at TIMEOUT_CYCLES=15 -> dmem_req drops after 15 cycles, err_timeout=1 stays set, and no write occurs; a variant with the ack on cycle 15 -> the write occurs and err_timeout stays 0.
REQ-045 ALU transfer to r0 -> reg_d_enable stays 0 and pending_valid stays 0.
REQ-046 rst asserted in WAIT_MEM -> the stage is IDLE immediately, dmem_req=0, and no write occurs after release.
